seg7_scan_driver: RTL and testbench

Downstream stage of the digit/number counter: accepts four BCD digits plus decimal points and drives a common-anode four-digit seven-segment display by time-multiplexing. Provides per-digit blanking against ghosting, optional leading-zero blanking and tear-free frame-boundary updates. All pin outputs are registered and active-low, matching PNP anode drivers and sinking segment pins.

---
 rtl/seg7_pkg.sv | 25 ++
 rtl/seg7_encode.sv | 29 ++
 rtl/seg7_scan_driver.sv | 114 +++++++++++
 tb/tb_seg7_scan_driver.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the four-digit seven-segment scan driver.
// Segment bit order: a..g on bits 0..6, active-low (0 = lit).
package seg7_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'h7F;

    typedef enum logic {
        SLOT_BLANK,
        SLOT_DRIVE
    } slot_state_t;

endpackage

// File: rtl/seg7_encode.sv
// Combinational BCD-to-segment decoder; non-decimal nibbles show a dash.
module seg7_encode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg_n
);

    always_comb begin
        seg_n = SEG_OFF;
        if (!blank) begin
            case (nibble)
                4'd0:    seg_n = SEG_0;
                4'd1:    seg_n = SEG_1;
                4'd2:    seg_n = SEG_2;
                4'd3:    seg_n = SEG_3;
                4'd4:    seg_n = SEG_4;
                4'd5:    seg_n = SEG_5;
                4'd6:    seg_n = SEG_6;
                4'd7:    seg_n = SEG_7;
                4'd8:    seg_n = SEG_8;
                4'd9:    seg_n = SEG_9;
                default: seg_n = SEG_DASH;
            endcase
        end
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode driver: per-slot anti-ghost blanking,
// optional leading-zero blanking and frame-boundary (tear-free) updates.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int CLK_DIV   = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] bcd_in,
    input  logic [3:0]  dp_in,
    input  logic        lzb_en,
    output logic [3:0]  anode_n,
    output logic [6:0]  seg_n,
    output logic        dp_n,
    output logic        frame_done
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC);
    localparam logic [IDX_W-1:0] LAST_DIG  = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]      slot_cnt;
    logic [IDX_W-1:0]      dig_idx;
    logic [15:0]           disp_bcd;
    logic [15:0]           pend_bcd;
    logic [3:0]            disp_dp;
    logic [3:0]            pend_dp;
    logic                  pend;
    slot_state_t           slot_state;
    logic                  frame_end;
    logic [3:0]            cur_nibble;
    logic                  cur_blank;
    logic [6:0]            enc_seg_n;
    logic                  zero3;
    logic                  zero2;
    logic                  zero1;
    logic [NUM_DIGITS-1:0] lz_mask;

    // A digit is a leading zero when it and every more significant nibble is 0.
    assign zero3   = (disp_bcd[15:12] == 4'h0);
    assign zero2   = (disp_bcd[11:8]  == 4'h0);
    assign zero1   = (disp_bcd[7:4]   == 4'h0);
    assign lz_mask = {zero3, zero3 & zero2, zero3 & zero2 & zero1, 1'b0};

    always_comb begin
        slot_state = (slot_cnt < BLANK_END) ? SLOT_BLANK : SLOT_DRIVE;
        frame_end  = (slot_cnt == SLOT_LAST) && (dig_idx == LAST_DIG);
        cur_nibble = disp_bcd[{dig_idx, 2'b00} +: 4];
        cur_blank  = lzb_en && lz_mask[dig_idx];
    end

    seg7_encode u_encode (
        .nibble (cur_nibble),
        .blank  (cur_blank),
        .seg_n  (enc_seg_n)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_cnt   <= '0;
            dig_idx    <= '0;
            disp_bcd   <= '0;
            disp_dp    <= '0;
            pend_bcd   <= '0;
            pend_dp    <= '0;
            pend       <= 1'b0;
            anode_n    <= 4'hF;
            seg_n      <= SEG_OFF;
            dp_n       <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            if (slot_cnt == SLOT_LAST) begin
                slot_cnt <= '0;
                dig_idx  <= dig_idx + IDX_W'(1);
            end else begin
                slot_cnt <= slot_cnt + CNT_W'(1);
            end

            frame_done <= frame_end;

            if (slot_state == SLOT_BLANK) begin
                anode_n <= 4'hF;
                seg_n   <= SEG_OFF;
                dp_n    <= 1'b1;
            end else begin
                anode_n <= ~(4'b0001 << dig_idx);
                seg_n   <= enc_seg_n;
                dp_n    <= ~disp_dp[dig_idx];
            end

            // A load on the boundary itself bypasses pend and shows next frame.
            if (frame_end) begin
                if (load) begin
                    disp_bcd <= bcd_in;
                    disp_dp  <= dp_in;
                end else if (pend) begin
                    disp_bcd <= pend_bcd;
                    disp_dp  <= pend_dp;
                end
                pend <= 1'b0;
            end else if (load) begin
                pend_bcd <= bcd_in;
                pend_dp  <= dp_in;
                pend     <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (CLK_DIV=8, BLANK_CYC=2) with a
// time-based reference model of what the pins should show each cycle.
module tb_seg7_scan_driver;

    localparam int CLK_DIV   = 8;
    localparam int BLANK_CYC = 2;
    localparam int FRAME     = 4 * CLK_DIV;
    localparam logic [12:0] PINS_IDLE = {4'hF, 7'h7F, 1'b1, 1'b0};
    localparam logic [6:0] P0 = 7'b1000000;
    localparam logic [6:0] P2 = 7'b0100100;
    localparam logic [6:0] P3 = 7'b0110000;
    localparam logic [6:0] PD = 7'b0111111;
    localparam logic [6:0] PX = 7'h7F;

    logic        clk;
    logic        rst;
    logic        load;
    logic [15:0] bcd_in;
    logic [3:0]  dp_in;
    logic        lzb_en;
    logic [3:0]  anode_n;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    int          m_pos;
    logic [15:0] m_disp;
    logic [15:0] m_pbcd;
    logic [3:0]  m_dp;
    logic [3:0]  m_pdp;
    logic        m_pend;
    logic [12:0] exp_pins;

    wire [12:0] act_pins = {anode_n, seg_n, dp_n, frame_done};

    seg7_scan_driver #(
        .CLK_DIV   (CLK_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .bcd_in     (bcd_in),
        .dp_in      (dp_in),
        .lzb_en     (lzb_en),
        .anode_n    (anode_n),
        .seg_n      (seg_n),
        .dp_n       (dp_n),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] spec_seg(input logic [3:0] nib);
        case (nib)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    // Pins for the counter position pos cycles after reset release.
    function automatic logic [12:0] model_pins(input int pos, input logic [15:0] disp,
                                               input logic [3:0] dp, input logic lzb);
        int         slot;
        int         dig;
        logic       fd;
        logic [6:0] seg;
        slot = pos % CLK_DIV;
        dig  = (pos / CLK_DIV) % 4;
        fd   = ((pos % FRAME) == FRAME - 1);
        if (slot < BLANK_CYC) return {4'hF, 7'h7F, 1'b1, fd};
        if (lzb && dig > 0 && (disp >> (4 * dig)) == 16'h0) seg = 7'h7F;
        else seg = spec_seg(disp[4*dig +: 4]);
        return {~(4'b0001 << dig), seg, ~dp[dig], fd};
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_pos    <= 0;
            m_disp   <= '0;
            m_dp     <= '0;
            m_pend   <= 1'b0;
            exp_pins <= PINS_IDLE;
        end else begin
            exp_pins <= model_pins(m_pos, m_disp, m_dp, lzb_en);
            if ((m_pos % FRAME) == FRAME - 1) begin
                if (load) begin
                    m_disp <= bcd_in;
                    m_dp   <= dp_in;
                end else if (m_pend) begin
                    m_disp <= m_pbcd;
                    m_dp   <= m_pdp;
                end
                m_pend <= 1'b0;
            end else if (load) begin
                m_pbcd <= bcd_in;
                m_pdp  <= dp_in;
                m_pend <= 1'b1;
            end
            m_pos <= m_pos + 1;
        end
    end

    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        bcd_in = v;
        dp_in  = d;
        load   = 1'b1;
        @(negedge clk);
        load   = 1'b0;
    endtask

    // Waits (bounded) for a frame_done pulse, then records the next full frame.
    task automatic capture_frame(output logic [27:0] segs, output logic [3:0] dps,
                                 output int diffs, output int overlaps, output bit timeout);
        int waited;
        segs = {28{1'b1}};
        dps = 4'hF;
        diffs = 0;
        overlaps = 0;
        timeout = 1'b0;
        waited = 0;
        while (frame_done !== 1'b1 && waited < 2 * FRAME) begin
            @(negedge clk);
            waited++;
            if (act_pins !== exp_pins) diffs++;
            if ($countones(~anode_n) > 1) overlaps++;
        end
        if (frame_done !== 1'b1) begin
            timeout = 1'b1;
            return;
        end
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            if (act_pins !== exp_pins) diffs++;
            if ($countones(~anode_n) > 1) overlaps++;
            for (int d = 0; d < 4; d++) begin
                if (anode_n[d] === 1'b0) begin
                    segs[7*d +: 7] = seg_n;
                    dps[d] = dp_n;
                end
            end
        end
    endtask

    task automatic test_reset();
        int first_low;
        int fd_count;
        int seg_bad;
        int drive_cnt[4];
        rst = 1'b1;
        load = 1'b0;
        lzb_en = 1'b0;
        bcd_in = '0;
        dp_in = '0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (act_pins !== PINS_IDLE) begin
                errors++;
                $display("[TB] FAIL reset_hold pins=%h expected=%h", act_pins, PINS_IDLE);
            end
        end
        rst = 1'b0;
        first_low = -1;
        fd_count = 0;
        seg_bad = 0;
        for (int d = 0; d < 4; d++) drive_cnt[d] = 0;
        for (int k = 1; k <= 64; k++) begin
            @(negedge clk);
            checks++;
            if (act_pins !== exp_pins) begin
                errors++;
                $display("[TB] FAIL idle_pins cycle=%0d pins=%h expected=%h", k, act_pins, exp_pins);
            end
            if (anode_n[0] === 1'b0 && first_low < 0) first_low = k;
            if (frame_done === 1'b1) fd_count++;
            for (int d = 0; d < 4; d++) begin
                if (anode_n[d] === 1'b0) begin
                    drive_cnt[d]++;
                    if (seg_n !== P0) seg_bad++;
                end
            end
        end
        checks++;
        if (first_low != BLANK_CYC + 1) begin
            errors++;
            $display("[TB] FAIL first_anode_low cycle=%0d expected=%0d", first_low, BLANK_CYC + 1);
        end
        checks++;
        if (fd_count != 2) begin
            errors++;
            $display("[TB] FAIL frame_done_count got=%0d expected=2", fd_count);
        end
        checks++;
        if (seg_bad != 0) begin
            errors++;
            $display("[TB] FAIL idle_digits_zero bad_cycles=%0d expected=0", seg_bad);
        end
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (drive_cnt[d] != 2 * (CLK_DIV - BLANK_CYC)) begin
                errors++;
                $display("[TB] FAIL drive_cycles digit=%0d got=%0d expected=%0d",
                         d, drive_cnt[d], 2 * (CLK_DIV - BLANK_CYC));
            end
        end
    endtask

    task automatic test_load_midframe();
        logic [27:0] segs;
        logic [3:0]  dps;
        int          diffs;
        int          ovl;
        bit          to;
        repeat (10) @(negedge clk);
        do_load(16'h1234, 4'b0100);
        capture_frame(segs, dps, diffs, ovl, to);
        checks++;
        if (to || diffs != 0 || ovl != 0) begin
            errors++;
            $display("[TB] FAIL midframe_pins diffs=%0d overlaps=%0d timeout=%0d expected 0/0/0", diffs, ovl, to);
        end
        checks++;
        if (segs !== {7'b1111001, P2, P3, 7'b0011001} || dps !== 4'b1011) begin
            errors++;
            $display("[TB] FAIL midframe_frame segs=%h dp_n=%b expected segs=%h dp_n=1011",
                     segs, dps, {7'b1111001, P2, P3, 7'b0011001});
        end
    endtask

    task automatic test_lzb();
        logic [27:0] segs;
        logic [3:0]  dps;
        int          diffs;
        int          ovl;
        bit          to;
        lzb_en = 1'b1;
        do_load(16'h0050, 4'b0000);
        capture_frame(segs, dps, diffs, ovl, to);
        checks++;
        if (to || diffs != 0 || segs !== {PX, PX, 7'b0010010, P0}) begin
            errors++;
            $display("[TB] FAIL lzb_0050 segs=%h diffs=%0d timeout=%0d expected segs=%h",
                     segs, diffs, to, {PX, PX, 7'b0010010, P0});
        end
        do_load(16'h0000, 4'b0000);
        capture_frame(segs, dps, diffs, ovl, to);
        checks++;
        if (to || diffs != 0 || segs !== {PX, PX, PX, P0}) begin
            errors++;
            $display("[TB] FAIL lzb_0000 segs=%h diffs=%0d timeout=%0d expected segs=%h",
                     segs, diffs, to, {PX, PX, PX, P0});
        end
        lzb_en = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [27:0] segs;
        logic [3:0]  dps;
        int          diffs;
        int          ovl;
        bit          to;
        repeat (5) @(negedge clk);
        do_load(16'h1111, 4'b0000);
        do_load(16'h2222, 4'b0000);
        capture_frame(segs, dps, diffs, ovl, to);
        checks++;
        if (to || diffs != 0 || segs !== {P2, P2, P2, P2}) begin
            errors++;
            $display("[TB] FAIL back_to_back segs=%h diffs=%0d timeout=%0d expected segs=%h",
                     segs, diffs, to, {P2, P2, P2, P2});
        end
    endtask

    task automatic test_boundary_load();
        logic [27:0] segs;
        logic [3:0]  dps;
        int          diffs;
        int          ovl;
        bit          to;
        int          waited;
        waited = 0;
        while (frame_done !== 1'b1 && waited < 2 * FRAME) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (frame_done !== 1'b1) begin
            errors++;
            $display("[TB] FAIL boundary_sync frame_done=%b expected=1", frame_done);
        end
        repeat (FRAME - 1) @(negedge clk);
        do_load(16'h3333, 4'b0000);
        checks++;
        if (frame_done !== 1'b1) begin
            errors++;
            $display("[TB] FAIL boundary_pulse frame_done=%b expected=1", frame_done);
        end
        capture_frame(segs, dps, diffs, ovl, to);
        checks++;
        if (to || diffs != 0 || segs !== {P3, P3, P3, P3}) begin
            errors++;
            $display("[TB] FAIL boundary_load segs=%h diffs=%0d timeout=%0d expected segs=%h",
                     segs, diffs, to, {P3, P3, P3, P3});
        end
    endtask

    task automatic test_invalid_digits();
        logic [27:0] segs;
        logic [3:0]  dps;
        int          diffs;
        int          ovl;
        bit          to;
        repeat (7) @(negedge clk);
        do_load(16'hFA98, 4'b0000);
        capture_frame(segs, dps, diffs, ovl, to);
        checks++;
        if (to || diffs != 0 || segs !== {PD, PD, 7'b0010000, 7'b0000000}) begin
            errors++;
            $display("[TB] FAIL invalid_digits segs=%h diffs=%0d timeout=%0d expected segs=%h",
                     segs, diffs, to, {PD, PD, 7'b0010000, 7'b0000000});
        end
    endtask

    task automatic test_random();
        logic [27:0] segs;
        logic [3:0]  dps;
        int          diffs;
        int          ovl;
        bit          to;
        logic [15:0] v;
        for (int it = 0; it < 8; it++) begin
            lzb_en = 1'($urandom_range(0, 1));
            v = 16'($urandom);
            v = v >> (4 * $urandom_range(0, 3));
            repeat ($urandom_range(0, 20)) @(negedge clk);
            do_load(v, 4'($urandom));
            capture_frame(segs, dps, diffs, ovl, to);
            checks++;
            if (to || diffs != 0 || ovl != 0) begin
                errors++;
                $display("[TB] FAIL random_%0d value=%h lzb=%b diffs=%0d overlaps=%0d timeout=%0d expected 0/0/0",
                         it, v, lzb_en, diffs, ovl, to);
            end
        end
        lzb_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [27:0] segs;
        logic [3:0]  dps;
        int          diffs;
        int          ovl;
        bit          to;
        int          waited;
        waited = 0;
        while (anode_n !== 4'b1011 && waited < 2 * FRAME) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (anode_n !== 4'b1011) begin
            errors++;
            $display("[TB] FAIL reset_mid_sync anode_n=%b expected=1011", anode_n);
        end
        do_load(16'h9876, 4'b1111);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (act_pins !== PINS_IDLE) begin
            errors++;
            $display("[TB] FAIL reset_mid_blank pins=%h expected=%h", act_pins, PINS_IDLE);
        end
        capture_frame(segs, dps, diffs, ovl, to);
        checks++;
        if (to || diffs != 0 || ovl != 0) begin
            errors++;
            $display("[TB] FAIL reset_mid_scan diffs=%0d overlaps=%0d timeout=%0d expected 0/0/0", diffs, ovl, to);
        end
        checks++;
        if (segs !== {P0, P0, P0, P0} || dps !== 4'hF) begin
            errors++;
            $display("[TB] FAIL reset_mid_pend_dropped segs=%h dp_n=%b expected segs=%h dp_n=1111",
                     segs, dps, {P0, P0, P0, P0});
        end
    endtask

    initial begin
        rst = 1'b1;
        load = 1'b0;
        lzb_en = 1'b0;
        bcd_in = '0;
        dp_in = '0;
        test_reset();
        test_load_midframe();
        test_lzb();
        test_back_to_back();
        test_boundary_load();
        test_invalid_digits();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
